// File: rtl/aes128_enc_iter_pkg.sv
// Shared AES-128 constants, types and byte-level round functions for the
// iterative encryption core and its key-expansion step.
package aes_pkg;

    localparam int NR_LEGAL = 10;

    typedef logic [31:0] word_t;
    // Element 15 holds byte 0 ([127:120]); element 0 holds byte 15.
    typedef logic [15:0][7:0] state_t;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} enc_fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        state_t r;
        for (int i = 0; i < 16; i++) r[i] = SBOX[s[i]];
        return r;
    endfunction

    // Byte (row r, column c) sits at position r + 4c; row r rotates left by r.
    function automatic state_t shift_rows(input state_t s);
        state_t r;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[15 - (row + 4 * c)] = s[15 - (row + 4 * ((c + row) % 4))];
        return r;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[15 - 4 * c];
            a1 = s[14 - 4 * c];
            a2 = s[13 - 4 * c];
            a3 = s[12 - 4 * c];
            r[15 - 4 * c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[14 - 4 * c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[13 - 4 * c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[12 - 4 * c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes128_enc_iter_if.sv
// Handshake/data bundle of the iterative AES-128 encryption core.
// Optional last_key signal is present when AES_ENC_LAST_KEY_EN is defined.
interface aes128_enc_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;
`ifdef AES_ENC_LAST_KEY_EN
    logic [127:0] last_key;

    modport master (output in_valid, key, plaintext, out_ready,
                    input  in_ready, out_valid, ciphertext, busy, last_key);
    modport slave  (input  in_valid, key, plaintext, out_ready,
                    output in_ready, out_valid, ciphertext, busy, last_key);
`else
    modport master (output in_valid, key, plaintext, out_ready,
                    input  in_ready, out_valid, ciphertext, busy);
    modport slave  (input  in_valid, key, plaintext, out_ready,
                    output in_ready, out_valid, ciphertext, busy);
`endif
endinterface

// File: rtl/aes128_enc_iter_key_expand.sv
// One forward AES-128 key-schedule step: next round key from current key
// and round constant. Purely combinational; shared with key-precompute logic.
module aes_key_expand_step
    import aes_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    output logic [127:0] key_out
);

    word_t w0, w1, w2, w3;
    word_t n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_in;

    assign n0 = w0 ^ sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: one round per clock, on-the-fly key
// expansion. Define AES_ENC_LAST_KEY_EN to expose the round-10 key.
module aes128_enc_iter
    import aes_pkg::*;
#(
    parameter int NR           = 10,
    parameter bit ZERO_ON_IDLE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    aes128_enc_iter_if.slave   bus
);

    generate
        if (NR != NR_LEGAL) begin : g_bad_nr
            $error("aes128_enc_iter: NR must be 10");
        end
    endgenerate

    localparam logic [3:0] LAST_RND = 4'(NR);

    enc_fsm_t     state_q, state_d;
    logic [3:0]   rnd_q;
    state_t       st_q;
    logic [127:0] key_q;
    logic [127:0] ct_hold_q;
    logic [127:0] rk;
    logic [7:0]   rcon_sel;
    logic         rnd_legal;
    logic         accept;
    state_t       sb_sr;
    state_t       round_out;

    assign rnd_legal = (rnd_q != 4'd0) && (rnd_q <= LAST_RND);
    assign rcon_sel  = rnd_legal ? RCON[rnd_q - 4'd1] : 8'h00;
    assign accept    = (state_q == IDLE) && bus.in_valid;

    aes_key_expand_step u_key_step (
        .key_in  (key_q),
        .rcon    (rcon_sel),
        .key_out (rk)
    );

    // The final round omits MixColumns.
    assign sb_sr     = shift_rows(sub_bytes(st_q));
    assign round_out = ((rnd_q == LAST_RND) ? sb_sr : mix_columns(sb_sr)) ^ rk;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: next state takes its default before the case, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = ROUND;
            ROUND: begin
                if (!rnd_legal)             state_d = IDLE;
                else if (rnd_q == LAST_RND) state_d = DONE;
            end
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: datapath registers get a reset value too, so an aborted block
    // leaves nothing behind that could reach the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q     <= '0;
            st_q      <= '0;
            key_q     <= '0;
            ct_hold_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        st_q  <= bus.plaintext ^ bus.key;
                        key_q <= bus.key;
                        rnd_q <= 4'd1;
                    end
                end
                ROUND: begin
                    if (!rnd_legal) begin
                        rnd_q <= '0;
                        st_q  <= '0;
                        key_q <= '0;
                    end else begin
                        st_q  <= round_out;
                        key_q <= rk;
                        // Counter parks at 0 after the last round so it never exceeds NR.
                        rnd_q <= (rnd_q == LAST_RND) ? 4'd0 : rnd_q + 4'd1;
                    end
                end
                DONE:    ct_hold_q <= st_q;
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.busy       = (state_q == ROUND) || (state_q == DONE);
    assign bus.ciphertext = bus.out_valid ? st_q : (ZERO_ON_IDLE ? '0 : ct_hold_q);

`ifdef AES_ENC_LAST_KEY_EN
    assign bus.last_key   = bus.out_valid ? key_q : '0;
`endif

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Directed self-checking bench for aes128_enc_iter using FIPS-197 and
// well-known AES-128 vectors.
module tb_aes128_enc_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    aes128_enc_iter_if bus_if ();

    aes128_enc_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] L2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K3 = 128'h0;
    localparam logic [127:0] P3 = 128'h0;
    localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_ready(input string tag);
        bit found = 1'b0;
        for (int t = 0; t < 50 && !found; t++) begin
            @(negedge clk);
            if (bus_if.in_ready) found = 1'b1;
        end
        check({tag, "_ready_timeout"}, found, 1'b1);
    endtask

    // Presents one block at the negedge; returns #1 after the accept edge.
    task automatic offer(input logic [127:0] k, input logic [127:0] p);
        bus_if.in_valid  = 1'b1;
        bus_if.key       = k;
        bus_if.plaintext = p;
        @(posedge clk);
        #1 bus_if.in_valid = 1'b0;
    endtask

    // Edges counted from the accept edge until out_valid; -1 on timeout.
    task automatic wait_out(input int already, output int lat);
        lat = already;
        for (int t = 0; t < 40; t++) begin
            if (bus_if.out_valid) return;
            @(posedge clk);
            #1 lat++;
        end
        if (!bus_if.out_valid) lat = -1;
    endtask

    task automatic run_vector(input string tag, input logic [127:0] k, input logic [127:0] p,
                              input logic [127:0] exp_ct, input logic [127:0] exp_lk, input bit chk_lk);
        int lat;
        wait_ready(tag);
        offer(k, p);
        check({tag, "_in_ready_low"}, bus_if.in_ready, 1'b0);
        check({tag, "_busy"}, bus_if.busy, 1'b1);
        wait_out(0, lat);
        check({tag, "_latency"}, 128'(lat), 128'(10));
        check({tag, "_ct"}, bus_if.ciphertext, exp_ct);
`ifdef AES_ENC_LAST_KEY_EN
        if (chk_lk) check({tag, "_last_key"}, bus_if.last_key, exp_lk);
`else
        if (chk_lk && exp_lk == '0) check({tag, "_lk_unused"}, 1'b0, 1'b1);
`endif
        @(posedge clk);
        #1;
        check({tag, "_out_valid_drop"}, bus_if.out_valid, 1'b0);
        check({tag, "_in_ready_back"}, bus_if.in_ready, 1'b1);
        check({tag, "_ct_zero_idle"}, bus_if.ciphertext, '0);
`ifdef AES_ENC_LAST_KEY_EN
        if (chk_lk) check({tag, "_last_key_idle"}, bus_if.last_key, '0);
`endif
    endtask

    initial begin
        logic [127:0] kv [3];
        logic [127:0] pv [3];
        logic [127:0] cv [3];
        int           acc [3];
        int           lat;
        bit           ok;
        bit           found;
        logic [127:0] snap;

        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        bus_if.key       = '0;
        bus_if.plaintext = '0;

        // Reset state
        #2;
        check("rst_in_ready", bus_if.in_ready, 1'b1);
        check("rst_out_valid", bus_if.out_valid, 1'b0);
        check("rst_busy", bus_if.busy, 1'b0);
        check("rst_ct", bus_if.ciphertext, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1 + 2: FIPS-197 vectors
        run_vector("v1", K1, P1, C1, '0, 1'b0);
        run_vector("v2", K2, P2, C2, L2, 1'b1);

        // 3: backpressure holds DONE and ignores in_valid
        bus_if.out_ready = 1'b0;
        wait_ready("bp");
        offer(K1, P1);
        wait_out(0, lat);
        check("bp_latency", 128'(lat), 128'(10));
        check("bp_ct", bus_if.ciphertext, C1);
        snap = bus_if.ciphertext;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus_if.in_valid  = i[0];
            bus_if.key       = rand128();
            bus_if.plaintext = rand128();
            @(posedge clk);
            #1;
            if (!bus_if.out_valid || bus_if.ciphertext !== snap || bus_if.in_ready || !bus_if.busy)
                ok = 1'b0;
        end
        check("bp_hold_stable", ok, 1'b1);
        @(negedge clk);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", bus_if.in_ready, 1'b1);
        check("bp_release_out_valid", bus_if.out_valid, 1'b0);

        // 4: inputs scrambled during rounds have no effect
        wait_ready("scr");
        offer(K2, P2);
        lat = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus_if.in_valid  = 1'b1;
            bus_if.key       = rand128();
            bus_if.plaintext = rand128();
            @(posedge clk);
            #1 lat++;
        end
        bus_if.in_valid = 1'b0;
        wait_out(lat, lat);
        check("scr_latency", 128'(lat), 128'(10));
        check("scr_ct", bus_if.ciphertext, C2);
        @(posedge clk);
        #1;

        // 5: asynchronous reset mid-block
        wait_ready("ar");
        offer(K1, P1);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_in_ready", bus_if.in_ready, 1'b1);
        check("ar_out_valid", bus_if.out_valid, 1'b0);
        check("ar_busy", bus_if.busy, 1'b0);
        check("ar_ct", bus_if.ciphertext, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid || bus_if.busy) ok = 1'b0;
        end
        check("ar_no_output_after", ok, 1'b1);
        run_vector("ar_v1", K1, P1, C1, '0, 1'b0);

        // 6: back-to-back with in_valid held high
        kv = '{K1, K2, K3};
        pv = '{P1, P2, P3};
        cv = '{C1, C2, C3};
        bus_if.out_ready = 1'b1;
        bus_if.in_valid  = 1'b1;
        bus_if.key       = kv[0];
        bus_if.plaintext = pv[0];
        for (int i = 0; i < 3; i++) begin
            found = 1'b0;
            for (int t = 0; t < 40 && !found; t++) begin
                @(negedge clk);
                if (bus_if.in_ready) found = 1'b1;
            end
            check($sformatf("b2b_accept_%0d", i), found, 1'b1);
            @(posedge clk);
            #1 acc[i] = cyc;
            if (i < 2) begin
                bus_if.key       = kv[i + 1];
                bus_if.plaintext = pv[i + 1];
            end else begin
                bus_if.in_valid = 1'b0;
            end
            wait_out(0, lat);
            check($sformatf("b2b_latency_%0d", i), 128'(lat), 128'(10));
            check($sformatf("b2b_ct_%0d", i), bus_if.ciphertext, cv[i]);
        end
        check("b2b_spacing_01", 128'(acc[1] - acc[0]), 128'(12));
        check("b2b_spacing_12", 128'(acc[2] - acc[1]), 128'(12));
        @(posedge clk);
        #1;
        check("b2b_final_idle", bus_if.in_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
